arp_encode: RTL and testbench
=============================

ARP_ENCODE -- requirements
Module: arp_encode

Interface
REQ-001 Parameter OPER, default 16'd2, ARP operation code transmitted (2 = reply).
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  request to transmit one ARP packet; sampled only in IDLE.
REQ-005 abort  input  1  terminate current packet immediately.
REQ-006 local_mac  input  48  sender hardware address (SHA).
REQ-007 local_ip  input  32  sender protocol address (SPA).
REQ-008 dst_mac  input  48  target hardware address (THA).
REQ-009 dst_ip  input  32  target protocol address (TPA).
REQ-010 dout  output  8  payload byte.
REQ-011 dout_valid  output  1  dout holds a valid byte.
REQ-012 dout_ready  input  1  downstream accepts byte when dout_valid && dout_ready.
REQ-013 dout_last  output  1  high with byte 27 (final byte).
REQ-014 busy  output  1  high in SEND and DONE.
REQ-015 done  output  1  one-cycle pulse after final byte accepted.

Function
REQ-016 Three states: IDLE, SEND, DONE.
REQ-017 IDLE: start=1 captures all four address inputs into internal registers, zeroes byte counter, moves to SEND; the first byte is presented the next cycle.
REQ-018 Address inputs are sampled only at capture; later changes do not affect the packet in flight.
REQ-019 SEND emits exactly 28 bytes, counter 0..27 (5-bit), advancing only on the handshake (dout_valid && dout_ready).
REQ-020 Byte order: 0x00,0x01 (HTYPE); 0x08,0x00 (PTYPE); 0x06 (HLEN); 0x04 (PLEN); OPER[15:8], OPER[7:0]; SHA x6; SPA x4; THA x6; TPA x4.
REQ-021 Address fields use the same packing as the arp_decode outputs: the first byte on the wire is bits [7:0], the last byte is the top byte. Decoded sha/spa can therefore drive dst_mac/dst_ip unmodified.
REQ-022 dout_valid is high for the whole of SEND.
REQ-023 While dout_valid && !dout_ready, dout, dout_valid and dout_last hold stable (AXI-Stream rule).
REQ-024 dout_last = 1 exactly when counter = 27 in SEND.
REQ-025 On handshake of byte 27: transition to DONE; dout_valid = 0 the next cycle.
REQ-026 DONE lasts one cycle, asserts done = 1, then returns to IDLE.
REQ-027 start during SEND or DONE is ignored, not queued.
REQ-028 start in the IDLE cycle immediately following DONE is accepted; minimum packet-to-packet gap is 2 idle-valid cycles.
REQ-029 abort in SEND or DONE: next cycle IDLE, dout_valid = 0, dout_last = 0, done = 0, counter = 0.
REQ-030 abort has priority over handshake and over start in the same cycle; abort in IDLE has no effect.
REQ-031 Throughput with dout_ready held high: one byte per cycle, 28 consecutive cycles.
REQ-032 dout = 0 whenever dout_valid = 0.

Reset
REQ-033 rst overrides everything including abort: state = IDLE, counter = 0, captured registers = 0, dout = 0, dout_valid = 0, dout_last = 0, busy = 0, done = 0.
REQ-034 rst mid-packet discards the packet; no done pulse is produced.

Structure
REQ-035 Package arp_pkg holds the following, shared with arp_decode: ARP_HTYPE_ETH (16'h0001), ARP_PTYPE_IPV4 (16'h0800), ARP_HLEN (8'd6), ARP_PLEN (8'd4), ARP_OPER_REQUEST (1), ARP_OPER_REPLY (2), ARP_LEN (28), and the state enum.
REQ-036 No sub-module; byte selection is a combinational case on the counter inside arp_encode.

Verification
REQ-037 local_mac=48'h665544332211, local_ip=32'h0A00A8C0, dst_mac=48'hFFEEDDCCBBAA, dst_ip=32'h0100A8C0, ready=1, start pulse -> 28 bytes 00 01 08 00 06 04 00 02 11 22 33 44 55 66 C0 A8 00 0A AA BB CC DD EE FF C0 A8 00 01 on consecutive cycles; last on byte 28; done one cycle later.
REQ-038 Same stimulus, dout_ready random 50% -> identical byte sequence; dout stable during every stall; done exactly once.
REQ-039 Loopback dout into arp_decode with OPER=1 -> decoder sha/spa/tha/tpa equal the encoder inputs; err = 0; done = 1.
REQ-040 start pulsed again at byte 10, inputs changed after capture -> output unchanged, no second packet.
REQ-041 abort asserted together with a handshake at byte 15 -> next cycle dout_valid = 0 and busy = 0, no done; a new start then sends byte 0 = 0x00 correctly.
REQ-042 rst at byte 20 -> all outputs 0 next cycle; a following start yields a full correct 28-byte packet.

Source files
------------

// File: rtl/arp_pkg.sv
// ----------------------------------------------------------------------------
// arp_pkg
// Constants and the control-state type shared by the ARP encoder and decoder.
// Field values are in wire order (big-endian for the fixed header words).
// ----------------------------------------------------------------------------
package arp_pkg;

    localparam logic [15:0] ARP_HTYPE_ETH    = 16'h0001;
    localparam logic [15:0] ARP_PTYPE_IPV4   = 16'h0800;
    localparam logic [7:0]  ARP_HLEN         = 8'd6;
    localparam logic [7:0]  ARP_PLEN         = 8'd4;
    localparam logic [15:0] ARP_OPER_REQUEST = 16'd1;
    localparam logic [15:0] ARP_OPER_REPLY   = 16'd2;

    // Payload length in bytes and index of the final byte.
    localparam int unsigned ARP_LEN  = 28;
    localparam logic [4:0]  ARP_LAST = 5'(ARP_LEN - 1);

    typedef enum logic [1:0] {
        ARP_IDLE = 2'd0,
        ARP_SEND = 2'd1,
        ARP_DONE = 2'd2
    } arp_state_t;

endpackage

// File: rtl/arp_encode.sv
// ----------------------------------------------------------------------------
// arp_encode
// Serialises one 28-byte ARP payload per start request onto a byte stream
// with valid/ready handshaking.
//
// Ports
//   clk, rst        clock (rising edge), synchronous active-high reset
//   start           request one packet; only looked at while idle
//   abort           drop the packet in flight immediately
//   local_mac/ip    sender hardware/protocol address (SHA/SPA)
//   dst_mac/ip      target hardware/protocol address (THA/TPA)
//   dout            payload byte, zero whenever dout_valid is low
//   dout_valid      byte available
//   dout_ready      downstream accepts the byte this cycle
//   dout_last       marks the final byte (index 27)
//   busy            packet in progress (SEND or DONE)
//   done            one-cycle pulse after the final byte is accepted
//
// Address fields go out low byte first, matching the packing arp_decode
// produces, so decoded addresses can be looped back unmodified.
// ----------------------------------------------------------------------------
module arp_encode
    import arp_pkg::*;
#(
    parameter logic [15:0] OPER = ARP_OPER_REPLY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [47:0] local_mac,
    input  logic [31:0] local_ip,
    input  logic [47:0] dst_mac,
    input  logic [31:0] dst_ip,
    output logic [7:0]  dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        dout_last,
    output logic        busy,
    output logic        done
);

    arp_state_t  state_q;
    logic [4:0]  cnt_q;
    logic [47:0] sha_q;
    logic [31:0] spa_q;
    logic [47:0] tha_q;
    logic [31:0] tpa_q;
    logic        valid_q;
    logic        last_q;
    logic        busy_q;
    logic        done_q;

    logic [7:0]  sel_byte;
    logic [7:0]  off;

    // Byte selection: counter drives a mux over header constants and the
    // captured address registers. The counter only moves on a handshake, so
    // the byte holds steady through stalls.
    always_comb begin
        sel_byte = '0;
        off      = '0;
        case (cnt_q)
            5'd0: sel_byte = ARP_HTYPE_ETH[15:8];
            5'd1: sel_byte = ARP_HTYPE_ETH[7:0];
            5'd2: sel_byte = ARP_PTYPE_IPV4[15:8];
            5'd3: sel_byte = ARP_PTYPE_IPV4[7:0];
            5'd4: sel_byte = ARP_HLEN;
            5'd5: sel_byte = ARP_PLEN;
            5'd6: sel_byte = OPER[15:8];
            5'd7: sel_byte = OPER[7:0];
            default: begin
                if (cnt_q < 5'd14) begin
                    off      = {cnt_q - 5'd8, 3'b000};
                    sel_byte = sha_q[off +: 8];
                end else if (cnt_q < 5'd18) begin
                    off      = {cnt_q - 5'd14, 3'b000};
                    sel_byte = spa_q[off +: 8];
                end else if (cnt_q < 5'd24) begin
                    off      = {cnt_q - 5'd18, 3'b000};
                    sel_byte = tha_q[off +: 8];
                end else if (cnt_q <= ARP_LAST) begin
                    off      = {cnt_q - 5'd24, 3'b000};
                    sel_byte = tpa_q[off +: 8];
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARP_IDLE;
            cnt_q   <= '0;
            sha_q   <= '0;
            spa_q   <= '0;
            tha_q   <= '0;
            tpa_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ARP_IDLE: begin
                    if (start) begin
                        sha_q   <= local_mac;
                        spa_q   <= local_ip;
                        tha_q   <= dst_mac;
                        tpa_q   <= dst_ip;
                        cnt_q   <= '0;
                        state_q <= ARP_SEND;
                        valid_q <= 1'b1;
                        last_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                    done_q <= 1'b0;
                end
                ARP_SEND: begin
                    if (abort) begin
                        state_q <= ARP_IDLE;
                        cnt_q   <= '0;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end else if (valid_q && dout_ready) begin
                        if (cnt_q == ARP_LAST) begin
                            state_q <= ARP_DONE;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q  <= cnt_q + 5'd1;
                            // last is registered, so flag it one step early
                            last_q <= (cnt_q + 5'd1 == ARP_LAST);
                        end
                    end
                end
                default: begin
                    // DONE (abort here lands in the same place)
                    state_q <= ARP_IDLE;
                    cnt_q   <= '0;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dout       = valid_q ? sel_byte : '0;
    assign dout_valid = valid_q;
    assign dout_last  = last_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_arp_encode.sv
module tb_arp_encode;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [47:0] local_mac;
    logic [31:0] local_ip;
    logic [47:0] dst_mac;
    logic [31:0] dst_ip;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        dout_last;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    arp_encode #(.OPER(16'd2)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .local_mac  (local_mac),
        .local_ip   (local_ip),
        .dst_mac    (dst_mac),
        .dst_ip     (dst_ip),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        logic [7:0] b;
        logic       last;
    } vec_t;

    vec_t tbl [28];
    logic [7:0] exp_b [28] = '{
        8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h02,
        8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
        8'hC0, 8'hA8, 8'h00, 8'h0A,
        8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF,
        8'hC0, 8'hA8, 8'h00, 8'h01
    };

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // All checks and input changes happen 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr();
        local_mac = 48'h665544332211;
        local_ip  = 32'h0A00A8C0;
        dst_mac   = 48'hFFEEDDCCBBAA;
        dst_ip    = 32'h0100A8C0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic idle_check(input string nm);
        chk({nm, "_valid"}, {47'd0, dout_valid}, 48'd0);
        chk({nm, "_dout"},  {40'd0, dout},       48'd0);
        chk({nm, "_last"},  {47'd0, dout_last},  48'd0);
        chk({nm, "_busy"},  {47'd0, busy},       48'd0);
        chk({nm, "_done"},  {47'd0, done},       48'd0);
    endtask

    // Ready held high: 28 bytes back to back, then a one-cycle DONE.
    task automatic expect_full_packet(input string nm);
        dout_ready = 1'b1;
        for (int i = 0; i < 28; i++) begin
            chk({nm, "_byte"},  {40'd0, dout},       {40'd0, tbl[i].b});
            chk({nm, "_valid"}, {47'd0, dout_valid}, 48'd1);
            chk({nm, "_last"},  {47'd0, dout_last},  {47'd0, tbl[i].last});
            chk({nm, "_busy"},  {47'd0, busy},       48'd1);
            chk({nm, "_done0"}, {47'd0, done},       48'd0);
            tick();
        end
        chk({nm, "_endvalid"}, {47'd0, dout_valid}, 48'd0);
        chk({nm, "_enddout"},  {40'd0, dout},       48'd0);
        chk({nm, "_donepulse"},{47'd0, done},       48'd1);
        chk({nm, "_donebusy"}, {47'd0, busy},       48'd1);
        tick();
        chk({nm, "_doneoff"},  {47'd0, done},       48'd0);
        chk({nm, "_busyoff"},  {47'd0, busy},       48'd0);
    endtask

    initial begin
        for (int i = 0; i < 28; i++) begin
            tbl[i].b    = exp_b[i];
            tbl[i].last = (i == 27);
        end

        rst = 1'b1; start = 1'b0; abort = 1'b0; dout_ready = 1'b0;
        set_addr();
        tick(); tick();
        idle_check("reset");
        rst = 1'b0;
        tick();
        idle_check("idle");

        // Basic packet, then a back-to-back packet started in the first IDLE cycle.
        do_start();
        expect_full_packet("pkt1");
        do_start();
        expect_full_packet("b2b");

        // Random backpressure: same sequence, stable during stalls, one done.
        begin
            int idx = 0;
            int ndone = 0;
            int after = 0;
            logic stalled = 1'b0;
            logic [7:0] prev = '0;
            logic prev_last = 1'b0;
            do_start();
            for (int cyc = 0; cyc < 400 && after < 4; cyc++) begin
                if (stalled) begin
                    chk("stall_dout",  {40'd0, dout},       {40'd0, prev});
                    chk("stall_last",  {47'd0, dout_last},  {47'd0, prev_last});
                    chk("stall_valid", {47'd0, dout_valid}, 48'd1);
                end
                if (done) ndone++;
                if (dout_valid && idx < 28) begin
                    chk("rnd_byte", {40'd0, dout},      {40'd0, tbl[idx].b});
                    chk("rnd_last", {47'd0, dout_last}, {47'd0, tbl[idx].last});
                end
                dout_ready = 1'($urandom_range(0, 1));
                stalled    = dout_valid && !dout_ready;
                prev       = dout;
                prev_last  = dout_last;
                if (dout_valid && dout_ready) idx++;
                if (idx == 28 && !dout_valid) after++;
                tick();
            end
            chk("rnd_count", 48'(idx),   48'd28);
            chk("rnd_done",  48'(ndone), 48'd1);
            idle_check("rnd_end");
        end

        // start again at byte 10 with new addresses; start during DONE ignored.
        do_start();
        dout_ready = 1'b1;
        for (int i = 0; i < 28; i++) begin
            chk("restart_byte", {40'd0, dout}, {40'd0, tbl[i].b});
            if (i == 10) begin
                start     = 1'b1;
                local_mac = 48'h123456789ABC;
                local_ip  = 32'hDEADBEEF;
                dst_mac   = 48'h0F0E0D0C0B0A;
                dst_ip    = 32'h01020304;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        chk("restart_done", {47'd0, done}, 48'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idle_check("nosecond");
            tick();
        end
        set_addr();

        // Abort together with the handshake of byte 15 (start also high).
        do_start();
        dout_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            chk("abort_pre", {40'd0, dout}, {40'd0, tbl[i].b});
            tick();
        end
        chk("abort_b15", {40'd0, dout}, {40'd0, tbl[15].b});
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            idle_check("aborted");
            tick();
        end

        // abort in IDLE is ignored: start with abort still launches a packet.
        abort = 1'b1;
        do_start();
        abort = 1'b0;
        expect_full_packet("abort_idle");

        // Reset at byte 20 discards the packet.
        do_start();
        dout_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("rst_pre", {40'd0, dout}, {40'd0, tbl[i].b});
            tick();
        end
        rst   = 1'b1;
        abort = 1'b1;
        tick();
        rst   = 1'b0;
        abort = 1'b0;
        for (int k = 0; k < 3; k++) begin
            idle_check("rst_mid");
            tick();
        end
        do_start();
        expect_full_packet("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
